// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : slave end of the MREQ/ACKD_n data bus, with a programmable
//                  number of wait states and byte/halfword/word lanes.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n
);

  localparam int         c_AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam state_t c_FIRST = (WAIT_CYCLES == 0) ? S_RESP : S_BUSY;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic        r_write;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_capture;
  logic            w_enter_resp;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [1:0]      w_size;
  logic            w_write;
  logic [c_AW-1:0] w_idx;
  logic [1:0]      w_off;
  logic            w_aligned;
  logic [3:0]      w_be;
  logic [31:0]     w_wlane;
  logic [31:0]     w_rword;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_capture    = MREQ && ((r_state == S_IDLE) || (r_state == S_RESP));
  assign w_enter_resp = (WAIT_CYCLES == 0) ? w_capture
                                           : ((r_state == S_BUSY) && (r_cnt == c_LAST));

  // With no wait states the commit edge is the capture edge, so use the live bus.
  assign w_addr  = (WAIT_CYCLES == 0) ? DAD   : r_addr;
  assign w_wdata = (WAIT_CYCLES == 0) ? DDT   : r_wdata;
  assign w_size  = (WAIT_CYCLES == 0) ? SIZE  : r_size;
  assign w_write = (WAIT_CYCLES == 0) ? WRITE : r_write;

  assign w_idx    = w_addr[c_AW+1:2];
  assign w_off    = w_addr[1:0];
  assign w_rword  = r_mem[w_idx] >> {w_off, 3'b000};
  assign w_unused = ^w_addr[31:c_AW+2];

  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wlane   = 32'h0;
    w_rdata   = 32'h0;
    case (w_size)
      2'b00: begin
        w_aligned = (w_off == 2'b00);
        w_be      = 4'b1111;
        w_wlane   = w_wdata;
        w_rdata   = w_rword;
      end
      2'b01: begin
        w_aligned = ~w_off[0];
        w_be      = 4'b0011 << w_off;
        w_wlane   = {16'h0, w_wdata[15:0]} << {w_off, 3'b000};
        w_rdata   = {16'h0, w_rword[15:0]};
      end
      2'b10: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << w_off;
        w_wlane   = {24'h0, w_wdata[7:0]} << {w_off, 3'b000};
        w_rdata   = {24'h0, w_rword[7:0]};
      end
      default: w_aligned = 1'b0;
    endcase
    if (!w_aligned) begin
      w_rdata = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (MREQ) w_state_next = c_FIRST;
      S_BUSY:  if (r_cnt == c_LAST) w_state_next = S_RESP;
      S_RESP:  w_state_next = MREQ ? c_FIRST : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_size  <= 2'b00;
      r_write <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      if (w_capture) begin
        r_cnt   <= 4'd0;
        r_addr  <= DAD;
        r_wdata <= DDT;
        r_size  <= SIZE;
        r_write <= WRITE;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_enter_resp && !w_write) begin
        r_rdata <= w_rdata;
      end
    end
  end

  // Storage is deliberately left unreset; misaligned writes simply never commit.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_write && w_aligned) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
    end
  end

  assign ACKD_n = (r_state != S_RESP);
  assign DDT    = ((r_state == S_RESP) && !r_write) ? r_rdata : 32'bz;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : checks a 1-wait-state and a 0-wait-state responder.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mreq [2];
  logic        wr   [2];
  logic [1:0]  sz   [2];
  logic [31:0] dad  [2];
  logic        drv  [2];
  logic [31:0] drvd [2];
  wire  [31:0] ddt0;
  wire  [31:0] ddt1;
  wire         ackn0;
  wire         ackn1;

  int errs   = 0;
  int checks = 0;
  logic [31:0] sb [$];

  typedef struct {
    int          d;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  assign ddt0 = drv[0] ? drvd[0] : 32'bz;
  assign ddt1 = drv[1] ? drvd[1] : 32'bz;

  dmem_responder #(.DEPTH_WORDS(16384), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .MREQ(mreq[0]), .WRITE(wr[0]), .SIZE(sz[0]),
    .DAD(dad[0]), .DDT(ddt0), .ACKD_n(ackn0)
  );

  dmem_responder #(.DEPTH_WORDS(16384), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .MREQ(mreq[1]), .WRITE(wr[1]), .SIZE(sz[1]),
    .DAD(dad[1]), .DDT(ddt1), .ACKD_n(ackn1)
  );

  function automatic logic ack(input int d);
    return (d == 1) ? ackn1 : ackn0;
  endfunction

  function automatic logic [31:0] ddt(input int d);
    return (d == 1) ? ddt1 : ddt0;
  endfunction

  function automatic vec_t mk(input int d, input logic w, input logic [1:0] s,
                              input logic [31:0] a, input logic [31:0] v);
    vec_t t;
    t.d = d; t.wr = w; t.sz = s; t.addr = a; t.data = v;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Drive zero onto the bus; any value the DUT still drives shows up as contention.
  task automatic probe_release(input int d, input string nm);
    drv[d]  = 1'b1;
    drvd[d] = 32'h0;
    #1;
    chk(nm, ddt(d), 32'h0);
    drv[d]  = 1'b0;
  endtask

  task automatic xact(input vec_t v);
    int n;
    logic [31:0] e;
    @(negedge clk);
    mreq[v.d] = 1'b1; wr[v.d] = v.wr; sz[v.d] = v.sz; dad[v.d] = v.addr;
    drv[v.d] = v.wr; drvd[v.d] = v.data;
    if (!v.wr) sb.push_back(v.data);
    @(posedge clk); #1;
    mreq[v.d] = 1'b0; drv[v.d] = 1'b0;
    n = 0;
    while (ack(v.d) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency@%08h", v.addr), n, (v.d == 1) ? 1 : 0);
    if (!v.wr) begin
      e = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
      chk($sformatf("rdata@%08h", v.addr), ddt(v.d), e);
    end else begin
      probe_release(v.d, $sformatf("wr_no_drive@%08h", v.addr));
    end
    @(posedge clk); #1;
    chk($sformatf("ack_one_cycle@%08h", v.addr), {31'h0, ack(v.d)}, 32'h1);
    probe_release(v.d, $sformatf("ddt_release@%08h", v.addr));
  endtask

  initial begin
    logic [31:0] b2b_addr [4];
    int lows;
    for (int i = 0; i < 2; i++) begin
      mreq[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'b00; dad[i] = 32'h0;
      drv[i] = 1'b0; drvd[i] = 32'h0;
    end

    vecs.push_back(mk(1, 1'b1, 2'b00, 32'h100, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1'b0, 2'b00, 32'h100, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1'b1, 2'b10, 32'h200, 32'h11));
    vecs.push_back(mk(1, 1'b1, 2'b10, 32'h201, 32'h22));
    vecs.push_back(mk(1, 1'b1, 2'b10, 32'h202, 32'h33));
    vecs.push_back(mk(1, 1'b1, 2'b10, 32'h203, 32'h44));
    vecs.push_back(mk(1, 1'b0, 2'b01, 32'h202, 32'h00004433));
    vecs.push_back(mk(1, 1'b0, 2'b00, 32'h200, 32'h44332211));
    vecs.push_back(mk(1, 1'b1, 2'b00, 32'h300, 32'h0));
    vecs.push_back(mk(1, 1'b1, 2'b01, 32'h301, 32'hABCD));
    vecs.push_back(mk(1, 1'b0, 2'b00, 32'h300, 32'h0));
    vecs.push_back(mk(1, 1'b0, 2'b01, 32'h301, 32'h0));
    vecs.push_back(mk(1, 1'b0, 2'b10, 32'h203, 32'h44));
    vecs.push_back(mk(1, 1'b1, 2'b01, 32'h102, 32'h5566));
    vecs.push_back(mk(1, 1'b0, 2'b00, 32'h100, 32'h5566BEEF));
    vecs.push_back(mk(1, 1'b0, 2'b11, 32'h100, 32'h0));
    vecs.push_back(mk(1, 1'b0, 2'b10, 32'h0001_0100, 32'hEF));
    vecs.push_back(mk(1, 1'b1, 2'b00, 32'h400, 32'h11112222));
    vecs.push_back(mk(0, 1'b1, 2'b00, 32'h0, 32'h0BADC0DE));
    vecs.push_back(mk(0, 1'b1, 2'b00, 32'h4, 32'hCAFEF00D));
    vecs.push_back(mk(0, 1'b1, 2'b00, 32'h8, 32'h12345678));
    vecs.push_back(mk(0, 1'b1, 2'b00, 32'hC, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 1'b0, 2'b01, 32'h0001_0006, 32'h0000CAFE));

    #12;
    chk("reset_ack0", {31'h0, ackn0}, 32'h1);
    chk("reset_ack1", {31'h0, ackn1}, 32'h1);
    probe_release(1, "reset_ddt1");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) xact(vecs[i]);

    // Zero wait states, MREQ held: one RESP per cycle, aliasing address included.
    b2b_addr[0] = 32'h0;      b2b_addr[1] = 32'h0001_0004;
    b2b_addr[2] = 32'h8;      b2b_addr[3] = 32'hC;
    sb.push_back(32'h0BADC0DE); sb.push_back(32'hCAFEF00D);
    sb.push_back(32'h12345678); sb.push_back(32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mreq[0] = 1'b1; wr[0] = 1'b0; sz[0] = 2'b00; dad[0] = b2b_addr[i];
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", i), {31'h0, ackn0}, 32'h0);
      chk($sformatf("b2b_rdata%0d", i), ddt0, sb.pop_front());
    end
    @(negedge clk);
    mreq[0] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {31'h0, ackn0}, 32'h1);

    // Reset asserted mid-cycle while a read is being acknowledged.
    @(negedge clk);
    mreq[1] = 1'b1; wr[1] = 1'b0; sz[1] = 2'b00; dad[1] = 32'h100;
    @(posedge clk); #1;
    mreq[1] = 1'b0;
    chk("rst_rd_busy", {31'h0, ackn1}, 32'h1);
    @(posedge clk); #1;
    chk("rst_rd_resp", {31'h0, ackn1}, 32'h0);
    chk("rst_rd_data", ddt1, 32'h5566BEEF);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ack", {31'h0, ackn1}, 32'h1);
    probe_release(1, "rst_async_ddt");
    @(negedge clk);
    rst = 1'b0;

    // Reset during BUSY of a write: no ACK and the old data survives.
    @(negedge clk);
    mreq[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'b00; dad[1] = 32'h400;
    drv[1] = 1'b1; drvd[1] = 32'h99999999;
    @(posedge clk); #1;
    mreq[1] = 1'b0; drv[1] = 1'b0;
    #1 rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (!ackn1) lows++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (!ackn1) lows++;
    end
    chk("rst_wr_no_ack", lows, 0);
    xact(mk(1, 1'b0, 2'b00, 32'h400, 32'h11112222));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
